// File: rtl/bank_rr_arbiter_pkg.sv
// Shared types and sizing helpers for the banked round-robin arbiter.
// Bank selection uses the low address bits.
package bank_arb_pkg;

  localparam int ADDR_WIDTH_D  = 4;
  localparam int VALUE_WIDTH_D = 8;

  typedef struct packed {
    logic                     we;
    logic [ADDR_WIDTH_D-1:0]  addr;
    logic [VALUE_WIDTH_D-1:0] wdata;
  } req_t;

  function automatic int bank_bits(int nbanks);
    return $clog2(nbanks);
  endfunction

  function automatic int baddr_width(int aw, int nbanks);
    return aw - $clog2(nbanks);
  endfunction

  function automatic int unsigned bank_of(
    logic [31:0] addr,
    int          nbanks
  );
    return addr & 32'(nbanks - 1);
  endfunction

endpackage

// File: rtl/bank_rr_arbiter_if.sv
// Consumer request/response and bank access bundle.
// The master side is the consumers plus memories; the slave is the arbiter.
interface bank_rr_arbiter_if
  import bank_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int VALUE_WIDTH = 8,
  parameter int NCONSUMERS  = 2,
  parameter int NBANKS      = 2,
  localparam int BADDR_WIDTH = baddr_width(ADDR_WIDTH, NBANKS),
  localparam int REQ_WIDTH   = ADDR_WIDTH + VALUE_WIDTH + 1
);

  logic [NCONSUMERS-1:0]  req_valid;
  logic [REQ_WIDTH-1:0]   requests [NCONSUMERS];
  logic [NCONSUMERS-1:0]  grant;
  logic [NBANKS-1:0]      bank_en;
  logic [NBANKS-1:0]      bank_we;
  logic [BADDR_WIDTH-1:0] bank_addr [NBANKS];
  logic [VALUE_WIDTH-1:0] bank_wdata [NBANKS];
  logic [VALUE_WIDTH-1:0] bank_rdata [NBANKS];
  logic [NCONSUMERS-1:0]  resp_valid;
  logic [VALUE_WIDTH-1:0] resp_data [NCONSUMERS];

  modport master (
    output req_valid, requests, bank_rdata,
    input  grant, bank_en, bank_we, bank_addr,
    input  bank_wdata, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, requests, bank_rdata,
    output grant, bank_en, bank_we, bank_addr,
    output bank_wdata, resp_valid, resp_data
  );

endinterface

// File: rtl/bank_rr_arbiter_rr.sv
// Single-bank round-robin arbiter: one-hot grant, first requester
// at or after the pointer, pointer moves past the winner.
module rr_arbiter #(
  parameter int N = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    int   idx;
    logic found;
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        ptr_d      = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bank_rr_arbiter.sv
// Banked arbiter top: steers requests to per-bank round-robin
// arbiters, issues accesses a cycle later, returns responses at +2.
module bank_rr_arbiter
  import bank_arb_pkg::*;
#(
  parameter int ADDR_WIDTH    = 4,
  parameter int VALUE_WIDTH   = 8,
  parameter int NCONSUMERS    = 2,
  parameter int NBANKS        = 2,
  parameter int COUNTER_WIDTH = 8,
  localparam int BANK_BITS   = bank_bits(NBANKS),
  localparam int BADDR_WIDTH = baddr_width(ADDR_WIDTH, NBANKS),
  localparam int REQ_WIDTH   = ADDR_WIDTH + VALUE_WIDTH + 1,
  localparam int CIW = (NCONSUMERS > 1) ? $clog2(NCONSUMERS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  bank_rr_arbiter_if.slave         bus,
  output logic [COUNTER_WIDTH-1:0] conflict_cnt
);

  logic [NCONSUMERS-1:0]  c_we;
  logic [ADDR_WIDTH-1:0]  c_addr  [NCONSUMERS];
  logic [BADDR_WIDTH-1:0] c_baddr [NCONSUMERS];
  logic [VALUE_WIDTH-1:0] c_wdata [NCONSUMERS];

  logic [NBANKS-1:0][NCONSUMERS-1:0] cand;
  logic [NBANKS-1:0][NCONSUMERS-1:0] gnt;
  logic [NBANKS-1:0] win_any;
  logic [CIW-1:0]    win_idx [NBANKS];

  logic [NBANKS-1:0]      en_q, we_q;
  logic [BADDR_WIDTH-1:0] addr_q  [NBANKS];
  logic [VALUE_WIDTH-1:0] wdata_q [NBANKS];
  logic [CIW-1:0]         own1_q  [NBANKS];
  logic [CIW-1:0]         own2_q  [NBANKS];
  logic [NBANKS-1:0]      vld2_q, we2_q;
  logic [NCONSUMERS-1:0]  rvld_q, rvld_d;

  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic                     stall;

  always_comb begin
    for (int c = 0; c < NCONSUMERS; c++) begin
      c_we[c]    = bus.requests[c][REQ_WIDTH-1];
      c_addr[c]  = bus.requests[c][VALUE_WIDTH +: ADDR_WIDTH];
      c_baddr[c] = c_addr[c][ADDR_WIDTH-1:BANK_BITS];
      c_wdata[c] = bus.requests[c][VALUE_WIDTH-1:0];
    end
  end

  // Reset masks candidates so no grant can leak out during reset.
  always_comb begin
    cand = '0;
    for (int b = 0; b < NBANKS; b++) begin
      for (int c = 0; c < NCONSUMERS; c++) begin
        cand[b][c] = bus.req_valid[c] & ~reset &
          (bank_of(32'(c_addr[c]), NBANKS) == 32'(b));
      end
    end
  end

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    rr_arbiter #(.N(NCONSUMERS)) u_arb (
      .clk   (clk),
      .reset (reset),
      .req_i (cand[b]),
      .gnt_o (gnt[b])
    );
  end

  always_comb begin
    bus.grant = '0;
    for (int b = 0; b < NBANKS; b++) begin
      bus.grant  = bus.grant | gnt[b];
      win_any[b] = |gnt[b];
      win_idx[b] = '0;
      for (int c = 0; c < NCONSUMERS; c++) begin
        if (gnt[b][c]) win_idx[b] = CIW'(c);
      end
    end
  end

  always_comb begin
    rvld_d = '0;
    for (int b = 0; b < NBANKS; b++) begin
      if (en_q[b]) rvld_d[own1_q[b]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q   <= '0;
      we_q   <= '0;
      vld2_q <= '0;
      we2_q  <= '0;
      rvld_q <= '0;
      for (int b = 0; b < NBANKS; b++) begin
        addr_q[b]  <= '0;
        wdata_q[b] <= '0;
        own1_q[b]  <= '0;
        own2_q[b]  <= '0;
      end
    end else begin
      en_q   <= win_any;
      vld2_q <= en_q;
      we2_q  <= we_q;
      rvld_q <= rvld_d;
      for (int b = 0; b < NBANKS; b++) begin
        own2_q[b] <= own1_q[b];
        if (win_any[b]) begin
          we_q[b]    <= c_we[win_idx[b]];
          addr_q[b]  <= c_baddr[win_idx[b]];
          wdata_q[b] <= c_wdata[win_idx[b]];
          own1_q[b]  <= win_idx[b];
        end
      end
    end
  end

  // Read data arrives with the response cycle, so it is muxed live.
  always_comb begin
    for (int c = 0; c < NCONSUMERS; c++) bus.resp_data[c] = '0;
    for (int b = 0; b < NBANKS; b++) begin
      if (vld2_q[b] && !we2_q[b]) begin
        bus.resp_data[own2_q[b]] = bus.bank_rdata[b];
      end
    end
  end

  assign bus.bank_en    = en_q;
  assign bus.bank_we    = we_q;
  assign bus.resp_valid = rvld_q;

  always_comb begin
    for (int b = 0; b < NBANKS; b++) begin
      bus.bank_addr[b]  = addr_q[b];
      bus.bank_wdata[b] = wdata_q[b];
    end
  end

  assign stall = |(bus.req_valid & ~bus.grant);

  always_comb begin
    cnt_d = cnt_q;
    if (stall && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_bank_rr_arbiter.sv
// Directed bench with a response scoreboard and per-bank memory model.
// Default parameters: 2 consumers, 2 banks, bank = addr[0].
module tb_bank_rr_arbiter;
  import bank_arb_pkg::*;

  localparam int AW  = 4;
  localparam int VW  = 8;
  localparam int NC  = 2;
  localparam int NB  = 2;
  localparam int CW  = 8;
  localparam int BAW = AW - 1;
  localparam int RW  = AW + VW + 1;

  typedef struct {
    int          due;
    logic [VW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] conflict_cnt;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;

  logic [VW-1:0] bmem [NB][2**BAW];
  logic [VW-1:0] rmem [NB][2**BAW];
  exp_t          sbq  [NC][$];

  bank_rr_arbiter_if #(
    .ADDR_WIDTH(AW), .VALUE_WIDTH(VW),
    .NCONSUMERS(NC), .NBANKS(NB)
  ) bus ();

  bank_rr_arbiter #(
    .ADDR_WIDTH(AW), .VALUE_WIDTH(VW),
    .NCONSUMERS(NC), .NBANKS(NB),
    .COUNTER_WIDTH(CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One-cycle-latency single-port memory per bank.
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (bus.bank_en[b]) begin
        if (bus.bank_we[b])
          bmem[b][bus.bank_addr[b]] <= bus.bank_wdata[b];
        bus.bank_rdata[b] <= bmem[b][bus.bank_addr[b]];
      end
    end
  end

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic logic [RW-1:0] mk(
    logic we, logic [AW-1:0] a, logic [VW-1:0] d
  );
    req_t r;
    r.we    = we;
    r.addr  = a;
    r.wdata = d;
    return r;
  endfunction

  // Scoreboard: push on accepted transfer, pop on resp_valid.
  always @(negedge clk) begin
    if (reset) begin
      for (int c = 0; c < NC; c++) sbq[c].delete();
    end else begin
      for (int c = 0; c < NC; c++) begin
        if (bus.resp_valid[c]) begin
          if (sbq[c].size() == 0) begin
            chk($sformatf("resp_unexp%0d", c),
                32'(bus.resp_valid[c]), 32'd0);
          end else begin
            exp_t e;
            e = sbq[c].pop_front();
            chk($sformatf("resp_cyc%0d", c), 32'(cyc), 32'(e.due));
            chk($sformatf("resp_data%0d", c),
                32'(bus.resp_data[c]), 32'(e.data));
          end
        end else if (sbq[c].size() != 0 && sbq[c][0].due <= cyc) begin
          chk($sformatf("resp_missing%0d", c),
              32'(bus.resp_valid[c]), 32'd1);
          void'(sbq[c].pop_front());
        end
        if (bus.req_valid[c] && bus.grant[c]) begin
          logic          we;
          logic [AW-1:0] a;
          exp_t          e;
          we     = bus.requests[c][RW-1];
          a      = bus.requests[c][VW +: AW];
          e.due  = cyc + 2;
          if (we) begin
            rmem[a[0]][a[AW-1:1]] = bus.requests[c][VW-1:0];
            e.data = '0;
          end else begin
            e.data = rmem[a[0]][a[AW-1:1]];
          end
          sbq[c].push_back(e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = '1;
    tick();
    tick();
    @(negedge clk);
    chk("grant_in_reset", 32'(bus.grant), 32'd0);
    tick();
    reset = 1'b0;
    bus.req_valid = '0;
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = '0;
    for (int c = 0; c < NC; c++) bus.requests[c] = '0;
    do_reset();

    @(negedge clk);
    chk("rst_bank_en", 32'(bus.bank_en), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_cnt", 32'(conflict_cnt), 32'd0);
    chk("rst_bank_addr0", 32'(bus.bank_addr[0]), 32'd0);
    chk("rst_bank_wdata1", 32'(bus.bank_wdata[1]), 32'd0);

    // Contention on bank 0
    tick();
    bus.req_valid = 2'b11;
    bus.requests[0] = mk(1'b1, 4'd2, 8'h11);
    bus.requests[1] = mk(1'b1, 4'd4, 8'h22);
    @(negedge clk);
    chk("t1_grant_n", 32'(bus.grant), 32'b01);
    tick();
    bus.req_valid = 2'b10;
    @(negedge clk);
    chk("t1_grant_n1", 32'(bus.grant), 32'b10);
    chk("t1_en_n1", 32'(bus.bank_en), 32'b01);
    tick();
    bus.req_valid = 2'b00;
    @(negedge clk);
    chk("t1_en_n2", 32'(bus.bank_en), 32'b01);
    chk("t1_resp_n2", 32'(bus.resp_valid), 32'b01);
    tick();
    @(negedge clk);
    chk("t1_resp_n3", 32'(bus.resp_valid), 32'b10);
    chk("t1_cnt", 32'(conflict_cnt), 32'd1);
    tick();
    tick();

    // Parallel banks
    do_reset();
    bus.req_valid = 2'b11;
    bus.requests[0] = mk(1'b1, 4'd1, 8'h33);
    bus.requests[1] = mk(1'b1, 4'd2, 8'h44);
    @(negedge clk);
    chk("t2_grant", 32'(bus.grant), 32'b11);
    tick();
    bus.req_valid = 2'b00;
    @(negedge clk);
    chk("t2_en", 32'(bus.bank_en), 32'b11);
    chk("t2_addr1", 32'(bus.bank_addr[1]), 32'd0);
    chk("t2_addr0", 32'(bus.bank_addr[0]), 32'd1);
    chk("t2_wdata1", 32'(bus.bank_wdata[1]), 32'h33);
    chk("t2_cnt", 32'(conflict_cnt), 32'd0);
    tick();
    tick();
    tick();

    // Write then read back
    bus.req_valid = 2'b01;
    bus.requests[0] = mk(1'b1, 4'd4, 8'hA5);
    @(negedge clk);
    chk("t3_grant_w", 32'(bus.grant), 32'b01);
    tick();
    bus.requests[0] = mk(1'b0, 4'd4, 8'h00);
    @(negedge clk);
    chk("t3_grant_r", 32'(bus.grant), 32'b01);
    tick();
    bus.req_valid = 2'b00;
    @(negedge clk);
    chk("t3_wresp_v", 32'(bus.resp_valid), 32'b01);
    chk("t3_wresp_d", 32'(bus.resp_data[0]), 32'd0);
    tick();
    @(negedge clk);
    chk("t3_rresp_v", 32'(bus.resp_valid), 32'b01);
    chk("t3_rresp_d", 32'(bus.resp_data[0]), 32'hA5);
    tick();
    tick();

    // Alternation on bank 1
    do_reset();
    bus.req_valid = 2'b11;
    bus.requests[0] = mk(1'b1, 4'd3, 8'h55);
    bus.requests[1] = mk(1'b1, 4'd5, 8'h66);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("t4_grant%0d", i), 32'(bus.grant),
          (i % 2 == 1) ? 32'b10 : 32'b01);
      tick();
    end
    bus.req_valid = 2'b00;
    @(negedge clk);
    chk("t4_cnt", 32'(conflict_cnt), 32'd6);
    tick();
    tick();
    tick();

    // Reset right after a grant
    do_reset();
    bus.req_valid = 2'b01;
    bus.requests[0] = mk(1'b1, 4'd6, 8'h77);
    @(negedge clk);
    chk("t5_grant", 32'(bus.grant), 32'b01);
    tick();
    reset = 1'b1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    chk("t5_grant_rst", 32'(bus.grant), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t5_noresp_n2", 32'(bus.resp_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("t5_noresp_n3", 32'(bus.resp_valid), 32'd0);
    tick();
    bus.req_valid = 2'b11;
    bus.requests[0] = mk(1'b1, 4'd2, 8'h01);
    bus.requests[1] = mk(1'b1, 4'd4, 8'h02);
    @(negedge clk);
    chk("t5_fresh0", 32'(bus.grant), 32'b01);
    tick();
    bus.req_valid = 2'b10;
    @(negedge clk);
    chk("t5_fresh1", 32'(bus.grant), 32'b10);
    tick();
    bus.req_valid = 2'b00;
    tick();
    tick();

    // Counter saturation under sustained contention
    do_reset();
    bus.req_valid = 2'b11;
    bus.requests[0] = mk(1'b1, 4'd1, 8'h5A);
    bus.requests[1] = mk(1'b1, 4'd3, 8'hC3);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      chk("t6_grant", 32'(bus.grant),
          (i % 2 == 1) ? 32'b10 : 32'b01);
      if (i == 200) chk("t6_cnt200", 32'(conflict_cnt), 32'd200);
      if (i == 255) chk("t6_cnt255", 32'(conflict_cnt), 32'hFF);
      if (i == 299) chk("t6_cnt299", 32'(conflict_cnt), 32'hFF);
      tick();
    end
    bus.req_valid = 2'b00;
    @(negedge clk);
    chk("t6_cnt_sat", 32'(conflict_cnt), 32'hFF);
    repeat (4) tick();
    @(negedge clk);
    chk("t6_cnt_hold", 32'(conflict_cnt), 32'hFF);

    for (int c = 0; c < NC; c++) begin
      chk($sformatf("sb_drain%0d", c), 32'(sbq[c].size()), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
